// File: rtl/mem_wb_stage_pkg.sv
// mem_wb_stage_pkg
// Shared definitions for the MEM stage and MEM/WB latch. It holds:
//   - the bit positions of the memory and writeback control buses
//   - the access-size encodings
//   - helpers for byte-lane enables and load extraction
// The data memory is organised as four 8-bit lanes. The helpers therefore
// assume a 32-bit word.
package mem_wb_stage_pkg;

  // memory_bus bit positions
  localparam int MB_MEM_READ  = 0;
  localparam int MB_MEM_WRITE = 1;
  localparam int MB_SIZE_LO   = 2;
  localparam int MB_SIZE_HI   = 3;
  localparam int MB_UNSIGNED  = 4;
  localparam int MB_BEQ       = 5;
  localparam int MB_BNE       = 6;

  // writeBack_bus bit positions
  localparam int WB_REG_WRITE  = 0;
  localparam int WB_MEM_TO_REG = 1;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'b00,
    SIZE_HALF = 2'b01,
    SIZE_RSVD = 2'b10,  // reserved, treated as a word access
    SIZE_WORD = 2'b11
  } mem_size_e;

  // Selects the byte lanes touched by an access.
  // A half access ignores offset[0]. A word access ignores the whole offset.
  function automatic logic [3:0] lane_enables(input logic [1:0] size,
                                              input logic [1:0] offset);
    logic [3:0] en;
    case (size)
      SIZE_BYTE: en = 4'b0001 << offset;
      SIZE_HALF: en = offset[1] ? 4'b1100 : 4'b0011;
      default:   en = 4'b1111;
    endcase
    return en;
  endfunction

  // Picks the addressed byte or half out of a word and extends it to 32 bits.
  function automatic logic [31:0] load_extract(input logic [31:0] word,
                                               input logic [1:0]  size,
                                               input logic [1:0]  offset,
                                               input logic        is_unsigned);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] res;
    b = word[{offset, 3'b000} +: 8];
    h = offset[1] ? word[31:16] : word[15:0];
    case (size)
      SIZE_BYTE: res = is_unsigned ? {24'b0, b} : {{24{b[7]}}, b};
      SIZE_HALF: res = is_unsigned ? {16'b0, h} : {{16{h[15]}}, h};
      default:   res = word;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/mem_wb_stage_if.sv
// mem_wb_stage_if
// Bundle of the EX/MEM latch outputs consumed by the memory stage.
//   master : EX/MEM latch side, drives every signal
//   slave  : memory stage side, receives every signal
// Signals:
//   in_pc_branch  : branch target
//   in_alu        : ALU result, also used as the byte address
//   in_zero_flag  : ALU zero flag
//   in_reg2       : store data
//   in_write_reg  : destination register
//   memory_bus    : memory control bus
//   writeBack_bus : writeback control bus
//   halt_flag_m   : halt marker
interface mem_wb_stage_if #(
  parameter int len_data    = 32,
  parameter int num_bits    = 5,
  parameter int len_mem_bus = 9,
  parameter int len_wb_bus  = 2
);
  logic [len_data-1:0]    in_pc_branch;
  logic [len_data-1:0]    in_alu;
  logic                   in_zero_flag;
  logic [len_data-1:0]    in_reg2;
  logic [num_bits-1:0]    in_write_reg;
  logic [len_mem_bus-1:0] memory_bus;
  logic [len_wb_bus-1:0]  writeBack_bus;
  logic                   halt_flag_m;

  modport master (
    output in_pc_branch, in_alu, in_zero_flag, in_reg2, in_write_reg,
           memory_bus, writeBack_bus, halt_flag_m
  );

  modport slave (
    input  in_pc_branch, in_alu, in_zero_flag, in_reg2, in_write_reg,
           memory_bus, writeBack_bus, halt_flag_m
  );
endinterface

// File: rtl/mem_wb_stage_data_memory.sv
// data_memory
// Byte-laned data memory of 2^len_addr 32-bit words.
// Behaviour:
//   - Writes are synchronous and update only the lanes that the access size
//     and offset select.
//   - The access port reads combinationally.
//   - A second combinational read port serves the debug unit.
//   - Contents start at zero and are never cleared by reset.
// Ports:
//   clk                   : clock
//   wr_en                 : write strobe for this cycle
//   size, byte_offset     : access size and byte offset
//   addr                  : word index
//   wr_data / rd_data     : store data in / raw word out
//   debug_addr/debug_data : debug read port
module data_memory
  import mem_wb_stage_pkg::*;
#(
  parameter int len_addr = 10
) (
  input  logic                clk,
  input  logic                wr_en,
  input  logic [1:0]          size,
  input  logic [1:0]          byte_offset,
  input  logic [len_addr-1:0] addr,
  input  logic [31:0]         wr_data,
  output logic [31:0]         rd_data,
  input  logic [len_addr-1:0] debug_addr,
  output logic [31:0]         debug_data
);

  localparam int depth = 1 << len_addr;

  logic [3:0][7:0] mem_array [depth] = '{default: '0};
  logic [3:0]      lane_en;
  logic [3:0][7:0] lane_data;

  assign lane_en = lane_enables(size, byte_offset);

  // Byte stores replicate the low byte onto every lane.
  // Half stores place the low half on both halves of the word.
  // Word stores map the data straight across.
  // lane_en then picks which lanes actually take the data.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      always_comb begin
        lane_data[gi] = wr_data[7:0];
        if (size == SIZE_WORD || size == SIZE_RSVD)
          lane_data[gi] = wr_data[8*gi +: 8];
        else if (size == SIZE_HALF)
          lane_data[gi] = wr_data[8*(gi % 2) +: 8];
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    for (int lane = 0; lane < 4; lane++) begin
      if (wr_en && lane_en[lane])
        mem_array[addr][lane] <= lane_data[lane];
    end
  end

  assign rd_data    = mem_array[addr];
  assign debug_data = mem_array[debug_addr];

endmodule

// File: rtl/mem_wb_stage.sv
// mem_wb_stage
// Memory stage and MEM/WB pipeline latch of the 5-stage MIPS core.
// Functions:
//   - resolves branches
//   - performs byte/half/word loads and stores on the internal data memory
//   - registers the MEM/WB values
//   - drives the writeback mux and the forwarding taps
// Optional feature: define MEM_MISALIGN_TRAP_EN to trap misaligned half/word
// accesses. A trapped access has its store suppressed and its register
// write cancelled, and sets the sticky misalign_err output.
// Ports:
//   clk, reset (async, active low), ctrl_clk_mips (advance enable)
//   ex_mem            : EX/MEM inputs (mem_wb_stage_if.slave)
//   debug_addr        : debug word address
//   pc_src            : branch taken (combinational)
//   out_pc_branch     : branch target (combinational)
//   ex_mem_reg_write  : forwarding tap, reg_write (combinational)
//   ex_mem_rd         : forwarding tap, destination (combinational)
//   out_read_data     : MEM/WB latch, load result
//   out_alu           : MEM/WB latch, ALU result
//   out_write_reg     : MEM/WB latch, destination register
//   writeBack_bus_out : MEM/WB latch, writeback control
//   out_halt_flag_m   : MEM/WB latch, halt marker
//   out_wb_data       : writeback mux result
//   debug_data        : memory word at debug_addr
//   misalign_err      : sticky trap flag (only with MEM_MISALIGN_TRAP_EN)
module mem_wb_stage
  import mem_wb_stage_pkg::*;
#(
  parameter int len_data    = 32,
  parameter int num_bits    = 5,
  parameter int len_mem_bus = 9,
  parameter int len_wb_bus  = 2,
  parameter int len_addr    = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ctrl_clk_mips,
  mem_wb_stage_if.slave         ex_mem,
  input  logic [len_addr-1:0]   debug_addr,
  output logic                  pc_src,
  output logic [len_data-1:0]   out_pc_branch,
  output logic                  ex_mem_reg_write,
  output logic [num_bits-1:0]   ex_mem_rd,
  output logic [len_data-1:0]   out_read_data,
  output logic [len_data-1:0]   out_alu,
  output logic [num_bits-1:0]   out_write_reg,
  output logic [len_wb_bus-1:0] writeBack_bus_out,
  output logic [len_data-1:0]   out_wb_data,
  output logic                  out_halt_flag_m,
  output logic [len_data-1:0]   debug_data
`ifdef MEM_MISALIGN_TRAP_EN
  ,
  output logic                  misalign_err
`endif
);

  logic                  mem_read;
  logic                  mem_write;
  logic                  load_unsigned;
  logic [1:0]            mem_size;
  logic [1:0]            byte_offset;
  logic [len_addr-1:0]   word_addr;
  logic [len_data-1:0]   rd_word;
  logic [len_data-1:0]   load_data;
  logic                  wr_en;
  logic                  unused_bits;

  logic [len_data-1:0]   read_data_reg;
  logic [len_data-1:0]   alu_reg;
  logic [num_bits-1:0]   write_reg_reg;
  logic [len_wb_bus-1:0] wb_bus_reg;
  logic                  halt_reg;

  assign mem_read      = ex_mem.memory_bus[MB_MEM_READ];
  assign mem_write     = ex_mem.memory_bus[MB_MEM_WRITE];
  assign load_unsigned = ex_mem.memory_bus[MB_UNSIGNED];
  assign mem_size      = ex_mem.memory_bus[MB_SIZE_HI:MB_SIZE_LO];
  assign byte_offset   = ex_mem.in_alu[1:0];
  // Address bits above the memory depth are dropped, so accesses wrap.
  assign word_addr     = ex_mem.in_alu[len_addr+1:2];
  assign unused_bits   = ^{ex_mem.in_alu[len_data-1:len_addr+2],
                           ex_mem.memory_bus[len_mem_bus-1:MB_BNE+1]};

  // Branch resolution and forwarding taps are pure pass-through.
  assign pc_src = (ex_mem.memory_bus[MB_BEQ] &  ex_mem.in_zero_flag) |
                  (ex_mem.memory_bus[MB_BNE] & ~ex_mem.in_zero_flag);
  assign out_pc_branch    = ex_mem.in_pc_branch;
  assign ex_mem_reg_write = ex_mem.writeBack_bus[WB_REG_WRITE];
  assign ex_mem_rd        = ex_mem.in_write_reg;

`ifdef MEM_MISALIGN_TRAP_EN
  logic misaligned;
  logic misalign_reg;

  assign misaligned = (mem_read | mem_write) &
                      (((mem_size == SIZE_HALF) & byte_offset[0]) |
                       (((mem_size == SIZE_WORD) | (mem_size == SIZE_RSVD)) &
                        (byte_offset != 2'b00)));
  assign wr_en = reset & ctrl_clk_mips & mem_write & ~misaligned;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      misalign_reg <= 1'b0;
    else if (ctrl_clk_mips && misaligned)
      misalign_reg <= 1'b1;
  end

  assign misalign_err = misalign_reg;
`else
  assign wr_en = reset & ctrl_clk_mips & mem_write;
`endif

  data_memory #(
    .len_addr(len_addr)
  ) u_data_memory (
    .clk        (clk),
    .wr_en      (wr_en),
    .size       (mem_size),
    .byte_offset(byte_offset),
    .addr       (word_addr),
    .wr_data    (ex_mem.in_reg2),
    .rd_data    (rd_word),
    .debug_addr (debug_addr),
    .debug_data (debug_data)
  );

  // The read sees the array before this edge's store, so a simultaneous
  // read+write returns the old word.
  assign load_data = load_extract(rd_word, mem_size, byte_offset, load_unsigned);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      read_data_reg <= '0;
      alu_reg       <= '0;
      write_reg_reg <= '0;
      wb_bus_reg    <= '0;
      halt_reg      <= 1'b0;
    end else if (ctrl_clk_mips) begin
      read_data_reg <= mem_read ? load_data : '0;
      alu_reg       <= ex_mem.in_alu;
      write_reg_reg <= ex_mem.in_write_reg;
`ifdef MEM_MISALIGN_TRAP_EN
      wb_bus_reg    <= misaligned ? '0 : ex_mem.writeBack_bus;
`else
      wb_bus_reg    <= ex_mem.writeBack_bus;
`endif
      halt_reg      <= ex_mem.halt_flag_m;
    end
  end

  assign out_read_data     = read_data_reg;
  assign out_alu           = alu_reg;
  assign out_write_reg     = write_reg_reg;
  assign writeBack_bus_out = wb_bus_reg;
  assign out_halt_flag_m   = halt_reg;
  assign out_wb_data       = wb_bus_reg[WB_MEM_TO_REG] ? read_data_reg : alu_reg;

endmodule

// File: tb/tb_mem_wb_stage.sv
// tb_mem_wb_stage
// Table of EX/MEM vectors with hand-derived load results. Each applied vector
// pushes its expected MEM/WB values into a scoreboard queue, which is popped
// and compared after the clock edge. Hand-written sequences cover stall,
// asynchronous reset and the debug port.
module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        ctrl_clk_mips = 1'b0;
  logic [9:0]  debug_addr = '0;
  logic        pc_src;
  logic [31:0] out_pc_branch;
  logic        ex_mem_reg_write;
  logic [4:0]  ex_mem_rd;
  logic [31:0] out_read_data;
  logic [31:0] out_alu;
  logic [4:0]  out_write_reg;
  logic [1:0]  writeBack_bus_out;
  logic [31:0] out_wb_data;
  logic        out_halt_flag_m;
  logic [31:0] debug_data;
`ifdef MEM_MISALIGN_TRAP_EN
  logic        misalign_err;
`endif

  always #5 clk = ~clk;

  mem_wb_stage_if ex_mem_bus ();

  mem_wb_stage dut (
    .clk              (clk),
    .reset            (reset),
    .ctrl_clk_mips    (ctrl_clk_mips),
    .ex_mem           (ex_mem_bus),
    .debug_addr       (debug_addr),
    .pc_src           (pc_src),
    .out_pc_branch    (out_pc_branch),
    .ex_mem_reg_write (ex_mem_reg_write),
    .ex_mem_rd        (ex_mem_rd),
    .out_read_data    (out_read_data),
    .out_alu          (out_alu),
    .out_write_reg    (out_write_reg),
    .writeBack_bus_out(writeBack_bus_out),
    .out_wb_data      (out_wb_data),
    .out_halt_flag_m  (out_halt_flag_m),
    .debug_data       (debug_data)
`ifdef MEM_MISALIGN_TRAP_EN
    ,
    .misalign_err     (misalign_err)
`endif
  );

  typedef struct {
    logic [8:0]  mb;
    logic [1:0]  wb;
    logic [31:0] alu;
    logic [31:0] reg2;
    logic [4:0]  rd;
    logic        zero;
    logic [31:0] exp_read;
    logic        exp_pc;
  } vec_t;

  typedef struct {
    logic [31:0] read_data;
    logic [31:0] alu;
    logic [4:0]  rd;
    logic [1:0]  wb;
    logic        halt;
    logic [31:0] wb_data;
  } exp_t;

  vec_t vecs[$];
  exp_t sb_q[$];
  exp_t last_exp;
  int   errors = 0;
  int   checks = 0;
  int   step_no = 0;

  localparam logic [1:0] SZ_B = 2'b00, SZ_H = 2'b01, SZ_R = 2'b10, SZ_W = 2'b11;

  function automatic logic [8:0] mb(input logic rd, input logic wr,
                                    input logic [1:0] sz, input logic uns);
    return {4'b0000, uns, sz, wr, rd};
  endfunction

  function automatic logic [8:0] mb_br(input logic beq, input logic bne);
    return {2'b00, bne, beq, 5'b00000};
  endfunction

  function automatic vec_t mkv(input logic [8:0] m, input logic [1:0] w,
                               input logic [31:0] a, input logic [31:0] r2,
                               input logic [4:0] rd, input logic z,
                               input logic [31:0] er, input logic ep);
    vec_t v;
    v.mb = m; v.wb = w; v.alu = a; v.reg2 = r2; v.rd = rd;
    v.zero = z; v.exp_read = er; v.exp_pc = ep;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_latch(input string tag, input exp_t e);
    chk({tag, " read_data"}, out_read_data, e.read_data);
    chk({tag, " alu"}, out_alu, e.alu);
    chk({tag, " write_reg"}, {27'b0, out_write_reg}, {27'b0, e.rd});
    chk({tag, " wb_bus"}, {30'b0, writeBack_bus_out}, {30'b0, e.wb});
    chk({tag, " halt"}, {31'b0, out_halt_flag_m}, {31'b0, e.halt});
    chk({tag, " wb_data"}, out_wb_data, e.wb_data);
  endtask

  // Drive one vector, check combinational taps, clock it, check the latch.
  task automatic step(input vec_t v, input logic en);
    exp_t  e;
    string tag;
    tag = $sformatf("step%0d", step_no);
    ex_mem_bus.memory_bus    = v.mb;
    ex_mem_bus.writeBack_bus = v.wb;
    ex_mem_bus.in_alu        = v.alu;
    ex_mem_bus.in_reg2       = v.reg2;
    ex_mem_bus.in_write_reg  = v.rd;
    ex_mem_bus.in_zero_flag  = v.zero;
    ex_mem_bus.in_pc_branch  = v.alu + 32'h0000_0100;
    ex_mem_bus.halt_flag_m   = v.rd[0];
    ctrl_clk_mips            = en;
    #1;
    chk({tag, " pc_src"}, {31'b0, pc_src}, {31'b0, v.exp_pc});
    chk({tag, " pc_branch"}, out_pc_branch, v.alu + 32'h0000_0100);
    chk({tag, " fwd_rw"}, {31'b0, ex_mem_reg_write}, {31'b0, v.wb[0]});
    chk({tag, " fwd_rd"}, {27'b0, ex_mem_rd}, {27'b0, v.rd});
    if (en) begin
      e.read_data = v.exp_read;
      e.alu       = v.alu;
      e.rd        = v.rd;
      e.wb        = v.wb;
      e.halt      = v.rd[0];
      e.wb_data   = v.wb[1] ? v.exp_read : v.alu;
    end else begin
      e = last_exp;
    end
    sb_q.push_back(e);
    last_exp = e;
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    check_latch(tag, e);
    $display("%s en=%0b mb=%h alu=%h read_data=%h wb_data=%h", tag, en, v.mb,
             v.alu, out_read_data, out_wb_data);
    step_no++;
  endtask

  initial begin
    exp_t zero_exp;
    vec_t v;
    zero_exp = '{default: '0};
    last_exp = zero_exp;
    ex_mem_bus.memory_bus    = '0;
    ex_mem_bus.writeBack_bus = '0;
    ex_mem_bus.in_alu        = '0;
    ex_mem_bus.in_reg2       = '0;
    ex_mem_bus.in_write_reg  = '0;
    ex_mem_bus.in_zero_flag  = 1'b0;
    ex_mem_bus.in_pc_branch  = '0;
    ex_mem_bus.halt_flag_m   = 1'b0;

    // Load results below are derived by hand from the store sequence.
    vecs.push_back(mkv(mb(0,1,SZ_W,0), 2'b00, 32'h10, 32'hDEADBEEF, 5'd0, 0, 32'h0, 0));
    vecs.push_back(mkv(mb(1,0,SZ_B,0), 2'b11, 32'h13, 32'h0, 5'd3, 0, 32'hFFFFFFDE, 0));
    vecs.push_back(mkv(mb(1,0,SZ_B,1), 2'b11, 32'h13, 32'h0, 5'd4, 0, 32'h000000DE, 0));
    vecs.push_back(mkv(mb(0,1,SZ_B,0), 2'b00, 32'h11, 32'h1234565A, 5'd0, 0, 32'h0, 0));
    vecs.push_back(mkv(mb(1,0,SZ_W,0), 2'b11, 32'h10, 32'h0, 5'd5, 0, 32'hDEAD5AEF, 0));
    vecs.push_back(mkv(mb(1,0,SZ_H,0), 2'b11, 32'h12, 32'h0, 5'd6, 0, 32'hFFFFDEAD, 0));
    vecs.push_back(mkv(mb(1,0,SZ_H,1), 2'b11, 32'h10, 32'h0, 5'd7, 0, 32'h00005AEF, 0));
    vecs.push_back(mkv(mb(0,1,SZ_W,0), 2'b00, 32'h14, 32'h11223344, 5'd0, 0, 32'h0, 0));
    vecs.push_back(mkv(mb(0,1,SZ_H,0), 2'b00, 32'h17, 32'hAAAA8077, 5'd0, 0, 32'h0, 0));
    vecs.push_back(mkv(mb(1,0,SZ_W,0), 2'b11, 32'h14, 32'h0, 5'd8, 0, 32'h80773344, 0));
    vecs.push_back(mkv(mb(1,0,SZ_B,0), 2'b11, 32'h14, 32'h0, 5'd9, 0, 32'h00000044, 0));
    vecs.push_back(mkv(mb(1,0,SZ_H,0), 2'b11, 32'h16, 32'h0, 5'd10, 0, 32'hFFFF8077, 0));
    vecs.push_back(mkv(mb(1,1,SZ_W,0), 2'b11, 32'h14, 32'hCAFEF00D, 5'd11, 0, 32'h80773344, 0));
    vecs.push_back(mkv(mb(1,0,SZ_W,0), 2'b11, 32'h14, 32'h0, 5'd12, 0, 32'hCAFEF00D, 0));
    vecs.push_back(mkv(mb(1,0,SZ_W,0), 2'b11, 32'h1014, 32'h0, 5'd13, 0, 32'hCAFEF00D, 0));
    vecs.push_back(mkv(mb(0,0,SZ_W,0), 2'b10, 32'h14, 32'h0, 5'd14, 0, 32'h0, 0));
    vecs.push_back(mkv(mb(0,1,SZ_R,0), 2'b00, 32'h18, 32'h0BADF00D, 5'd0, 0, 32'h0, 0));
    vecs.push_back(mkv(mb(1,0,SZ_W,0), 2'b11, 32'h18, 32'h0, 5'd15, 0, 32'h0BADF00D, 0));
    vecs.push_back(mkv(mb(0,1,SZ_W,0), 2'b00, 32'h1C, 32'h00000077, 5'd0, 0, 32'h0, 0));
    vecs.push_back(mkv(mb(1,0,SZ_W,0), 2'b11, 32'h1C, 32'h0, 5'd16, 0, 32'h00000077, 0));
    vecs.push_back(mkv(9'h000, 2'b01, 32'h42, 32'h0, 5'd17, 0, 32'h0, 0));
    vecs.push_back(mkv(mb_br(1,0), 2'b00, 32'h400, 32'h0, 5'd0, 1, 32'h0, 1));
    vecs.push_back(mkv(mb_br(0,1), 2'b00, 32'h404, 32'h0, 5'd0, 1, 32'h0, 0));
    vecs.push_back(mkv(mb_br(1,0), 2'b00, 32'h408, 32'h0, 5'd0, 0, 32'h0, 0));
    vecs.push_back(mkv(mb_br(0,1), 2'b00, 32'h40C, 32'h0, 5'd0, 0, 32'h0, 1));
    vecs.push_back(mkv(mb(0,1,SZ_W,0), 2'b00, 32'h20, 32'h00000055, 5'd0, 0, 32'h0, 0));

    // Reset held low across edges, then released with no operations.
    repeat (2) @(posedge clk);
    #1;
    check_latch("in_reset", zero_exp);
    reset = 1'b1;
    step(mkv(9'h000, 2'b00, 32'h0, 32'h0, 5'd0, 0, 32'h0, 0), 1'b1);

    foreach (vecs[i]) step(vecs[i], 1'b1);

    debug_addr = 10'd4;
    #1;
    chk("debug_word4", debug_data, 32'hDEAD5AEF);
    debug_addr = 10'd8;
    #1;
    chk("debug_word8_pre", debug_data, 32'h00000055);

    // Stalled store must neither write memory nor move the latch.
    v = mkv(mb(0,1,SZ_W,0), 2'b01, 32'h20, 32'h00001234, 5'd9, 0, 32'h0, 0);
    step(v, 1'b0);
    chk("stall_no_write", debug_data, 32'h00000055);
    step(v, 1'b1);
    chk("enable_write", debug_data, 32'h00001234);

    // Asynchronous reset mid-cycle with nonzero latch contents.
    #2;
    reset = 1'b0;
    #2;
    check_latch("async_reset", zero_exp);
    last_exp = zero_exp;
    @(posedge clk);
    #1;
    check_latch("reset_held", zero_exp);
    reset = 1'b1;
    #1;
    chk("mem_retained", debug_data, 32'h00001234);
    step(mkv(mb(1,0,SZ_W,0), 2'b11, 32'h20, 32'h0, 5'd18, 0, 32'h00001234, 0), 1'b1);

    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d expected 0", sb_q.size());
    end
    checks++;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
Memory stage plus MEM/WB pipeline latch of the 5-stage MIPS core, directly downstream of the execute/EX-MEM latch. Consumes the EX/MEM-registered ALU result, store data, destination register, memory/writeback control buses, branch target and zero flag. Resolves branches, performs byte/half/word loads and stores on an internal data memory, and registers the MEM/WB outputs. Also drives the writeback mux result and the forwarding sources used by the execute stage, and exposes a debug read port for the debug unit.

Parameters:
len_data, 32, datapath width
num_bits, 5, register-index width
len_mem_bus, 9, memory control bus width
len_wb_bus, 2, writeback control bus width
len_addr, 10, data-memory word-address bits (depth 2^len_addr words)

Ports:
clk  in  1  core clock
reset  in  1  asynchronous, active-low reset
ctrl_clk_mips  in  1  pipeline advance enable from debug unit (0 = stall, hold all state)
in_pc_branch  in  len_data  branch target from EX/MEM
in_alu  in  len_data  ALU result / byte address
in_zero_flag  in  1  ALU zero flag
in_reg2  in  len_data  store data
in_write_reg  in  num_bits  destination register
memory_bus  in  len_mem_bus  [0] mem_read, [1] mem_write, [3:2] size (00 byte, 01 half, 11 word, 10 reserved = word), [4] load unsigned, [5] beq, [6] bne, [8:7] reserved
writeBack_bus  in  len_wb_bus  [0] reg_write, [1] mem_to_reg
halt_flag_m  in  1  halt marker travelling with the instruction
debug_addr  in  len_addr  debug word address
pc_src  out  1  branch taken (combinational)
out_pc_branch  out  len_data  = in_pc_branch (combinational)
ex_mem_reg_write  out  1  = writeBack_bus[0] (combinational, to forwarding unit)
ex_mem_rd  out  num_bits  = in_write_reg (combinational)
out_read_data  out  len_data  registered load result
out_alu  out  len_data  registered ALU result
out_write_reg  out  num_bits  registered destination
writeBack_bus_out  out  len_wb_bus  registered writeback control
out_wb_data  out  len_data  out_wb data: mem_to_reg ? out_read_data : out_alu (combinational from registers)
out_halt_flag_m  out  1  registered halt marker
debug_data  out  len_data  memory word at debug_addr (combinational)

Behaviour:
- Reset (reset=0, async): all registered outputs 0; data memory NOT cleared (zero only at elaboration).
- pc_src = (beq & in_zero_flag) | (bne & ~in_zero_flag); combinational, no latency.
- Word index = in_alu[len_addr+1:2]; byte offset = in_alu[1:0]; upper address bits ignored (wrap).
- Store: on posedge clk with reset=1, ctrl_clk_mips=1, mem_write=1: byte writes in_reg2[7:0] into lane offset; half writes in_reg2[15:0] into lanes {offset[1],0},{offset[1],1} (offset[0] ignored); word writes all lanes (offset ignored). Other lanes unchanged.
- Load: combinational array read; byte/half extracted by offset (same lane rules), sign-extended unless unsigned=1; latched into out_read_data at posedge. Load latency 1 cycle. mem_read=0 → out_read_data latches 0.
- Same-cycle read-after-write to same word: store in cycle N visible to load in cycle N+1 only.
- ctrl_clk_mips=0: no memory write, all registers hold; reset still dominates.
- Latch on advance: out_alu←in_alu, out_write_reg←in_write_reg, writeBack_bus_out←writeBack_bus, out_halt_flag_m←halt_flag_m.
- mem_read and mem_write both 1: write performed, load data is the pre-write word.
- debug_data always reflects current array, independent of stall.

Optional Feature:
MEM_MISALIGN_TRAP_EN: when defined, half with offset[0]=1 or word with offset≠0 is misaligned: store suppressed, writeBack_bus_out latched 0 (no register write), sticky output misalign_err (1 bit) set, cleared only by reset. When undefined, port absent and low offset bits ignored as above.

Decomposition:
- Shared package/header: memory_bus bit indices, size encodings (SIZE_BYTE/HALF/WORD), writeback bus bit indices.
- One sub-module: data_memory (byte-lane write enables, combinational read, debug read port).

Test Plan:
- Reset released, ctrl_clk_mips=1, no ops → all outputs 0; pulse reset=0 mid-run with nonzero latches → outputs 0 immediately, memory contents retained.
- Store word 0xDEADBEEF at 0x10, then load byte signed at 0x13 → out_read_data=0xFFFFFFDE one cycle after load; unsigned → 0x000000DE.
- Store byte 0x5A at 0x11 over 0xDEADBEEF, load word 0x10 → 0xDEAD5AEF; debug_addr=4 → debug_data=0xDEAD5AEF.
- beq with zero=1 → pc_src=1, out_pc_branch=target same cycle; bne with zero=1 → pc_src=0.
- ctrl_clk_mips=0 with store 0x1234 to 0x20 → memory and latches unchanged; raise enable → write occurs.
- mem_to_reg=1, load 0x00000077 → out_wb_data=0x77; mem_to_reg=0, in_alu=0x42 → out_wb_data=0x42.
